pc_gen: RTL and testbench

//   Parametrised program-counter generator for the RISC-V fetch stage. Successor to the

---
 rtl/pc_gen.sv | 96 +++++++++
 tb/tb_pc_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// ============================================================================
//  Module   : pc_gen
//  Brief    : RISC-V fetch-stage program-counter generator with valid/ready
//             handshake, redirect and trap entry, misaligned-target fault state
//             and an accepted-fetch counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pc_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] c_BOOT  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FAULT = 2'd2;

  // Mask form keeps ALIGN_BITS = 0 legal without a reversed part-select.
  localparam logic [XLEN-1:0] c_ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_transfer;
  logic             w_target_ok;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= c_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_transfer  = (state_q == c_RUN) && pc_ready;
  assign w_target_ok = (redirect_target & c_ALIGN_MASK) == '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    if (w_transfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (trap_valid) begin
      pc_d    = trap_vector & ~c_ALIGN_MASK;
      state_d = c_RUN;
    end else begin
      case (state_q)
        c_BOOT: state_d = c_RUN;
        c_RUN: begin
          if (redirect_valid) begin
            // Offending target is kept on pc so the trap handler can report it.
            pc_d    = redirect_target;
            state_d = w_target_ok ? c_RUN : c_FAULT;
          end else if (w_transfer) begin
            pc_d = pc_q + XLEN'(STEP);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pc          = pc_q;
    fetch_count = cnt_q;
    pc_valid    = (state_q == c_RUN);
    misaligned  = (state_q == c_FAULT);
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
//  Module   : tb_pc_gen
//  Brief    : Directed self-checking bench for pc_gen (32-bit and 64-bit builds).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        clr, pc_ready, redirect_valid, trap_valid;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] pc;
  logic        pc_valid, misaligned;
  logic [31:0] fetch_count;

  logic        clr64, ready64;
  logic [63:0] pc64;
  logic        valid64, mis64;
  logic [1:0]  cnt64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk             (clk),
    .clr             (clr),
    .pc_ready        (pc_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .misaligned      (misaligned),
    .fetch_count     (fetch_count)
  );

  pc_gen #(
    .XLEN         (64),
    .RESET_VECTOR (64'hFFFF_FFFF_FFFF_FFFC),
    .CNT_W        (2)
  ) u_dut64 (
    .clk             (clk),
    .clr             (clr64),
    .pc_ready        (ready64),
    .redirect_valid  (1'b0),
    .redirect_target (64'h0),
    .trap_valid      (1'b0),
    .trap_vector     (64'h0),
    .pc              (pc64),
    .pc_valid        (valid64),
    .misaligned      (mis64),
    .fetch_count     (cnt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic e_m, input logic [31:0] e_cnt);
    chk({tag, ".pc"},  64'(pc),          64'(e_pc));
    chk({tag, ".val"}, 64'(pc_valid),    64'(e_v));
    chk({tag, ".mis"}, 64'(misaligned),  64'(e_m));
    chk({tag, ".cnt"}, 64'(fetch_count), 64'(e_cnt));
  endtask

  initial begin
    clr = 1'b1; pc_ready = 1'b1; redirect_valid = 1'b0; trap_valid = 1'b0;
    redirect_target = '0; trap_vector = '0;
    clr64 = 1'b1; ready64 = 1'b1;

    // Reset and sequential fetch
    tick(); tick();
    chk_all("rst", 32'h0, 1'b0, 1'b0, 32'd0);
    clr = 1'b0;
    tick(); chk_all("boot", 32'h0, 1'b1, 1'b0, 32'd0);
    tick(); chk_all("seq1", 32'h4, 1'b1, 1'b0, 32'd1);
    tick(); chk_all("seq2", 32'h8, 1'b1, 1'b0, 32'd2);
    tick(); tick(); chk_all("seq4", 32'h10, 1'b1, 1'b0, 32'd4);

    // Stall
    pc_ready = 1'b0;
    tick(); tick(); tick(); chk_all("stall", 32'h10, 1'b1, 1'b0, 32'd4);
    pc_ready = 1'b1;
    tick(); chk_all("resume", 32'h14, 1'b1, 1'b0, 32'd5);

    // Aligned redirects with same-cycle transfer
    redirect_valid = 1'b1; redirect_target = 32'h20;
    tick(); chk_all("rd20", 32'h20, 1'b1, 1'b0, 32'd6);
    redirect_target = 32'h100;
    tick(); chk_all("rd100", 32'h100, 1'b1, 1'b0, 32'd7);

    // Misaligned redirect -> FAULT, frozen
    redirect_target = 32'h102;
    tick(); chk_all("fault", 32'h102, 1'b0, 1'b1, 32'd8);
    redirect_target = 32'h200;
    tick(); tick(); chk_all("frozen", 32'h102, 1'b0, 1'b1, 32'd8);
    redirect_valid = 1'b0;
    trap_valid = 1'b1; trap_vector = 32'h207;
    tick(); chk_all("trapexit", 32'h204, 1'b1, 1'b0, 32'd8);

    // Trap beats redirect; transfer still counted
    redirect_valid = 1'b1; redirect_target = 32'h40; trap_vector = 32'h80;
    tick(); chk_all("trapprio", 32'h80, 1'b1, 1'b0, 32'd9);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    tick(); chk_all("posttrap", 32'h84, 1'b1, 1'b0, 32'd10);

    // clr during FAULT, overriding a trap
    redirect_valid = 1'b1; redirect_target = 32'h3;
    tick(); chk_all("fault2", 32'h3, 1'b0, 1'b1, 32'd11);
    redirect_valid = 1'b0;
    clr = 1'b1; trap_valid = 1'b1; trap_vector = 32'h500;
    tick(); chk_all("clrfault", 32'h0, 1'b0, 1'b0, 32'd0);
    trap_valid = 1'b0; clr = 1'b0;

    // Redirect in BOOT ignored
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick(); chk_all("bootrd", 32'h0, 1'b1, 1'b0, 32'd0);
    redirect_valid = 1'b0;
    tick(); chk_all("run4", 32'h4, 1'b1, 1'b0, 32'd1);

    // clr mid-stall
    pc_ready = 1'b0;
    tick(); chk_all("stall2", 32'h4, 1'b1, 1'b0, 32'd1);
    clr = 1'b1;
    tick(); chk_all("clrstall", 32'h0, 1'b0, 1'b0, 32'd0);
    clr = 1'b0;

    // 64-bit build: pc wrap and counter wrap (CNT_W=2)
    clr64 = 1'b0;
    chk("w64.rst", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); chk("w64.boot", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w64.val", 64'(valid64), 64'h1);
    tick(); chk("w64.wrap", pc64, 64'h0);
    chk("w64.cnt1", 64'(cnt64), 64'd1);
    tick(); tick(); tick();
    chk("w64.pc12", pc64, 64'hC);
    chk("w64.cntwrap", 64'(cnt64), 64'd0);
    chk("w64.mis", 64'(mis64), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
